// File: rtl/reg_write_arbiter_pkg.sv
// Shared types for the register-bank write arbiter: FSM state encoding and grant counter width.
// Per-instance widths (address, grant index) live in the module, not here.
package reg_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr, wrapping modulo N.
// Zero latency; no backpressure, o_any=0 when no request is set.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register bank among NREQ writers, with locked bursts; REG_ARB_STATS_EN adds per-requester grant counters.
// Accepted beat drives reg_load/reg_in/grant_id the next cycle; req_ready is one-hot and only follows req_valid.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NREG  = 8,
    parameter int WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NREQ-1:0]                        req_valid,
    input  logic [NREQ-1:0]                        req_lock,
    input  logic [NREQ-1:0][$clog2(NREG)-1:0]      req_addr,
    input  logic [NREQ-1:0][WIDTH-1:0]             req_data,
    output logic [NREQ-1:0]                        req_ready,
    output logic [NREG-1:0]                        reg_load,
    output logic [WIDTH-1:0]                       reg_in,
    output logic [$clog2(NREQ)-1:0]                grant_id,
`ifdef REG_ARB_STATS_EN
    output logic [NREQ-1:0][CNT_W-1:0]             grant_count,
`endif
    output logic                                   locked
);

    localparam int AW = $clog2(NREG);
    localparam int IW = $clog2(NREQ);

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic [AW-1:0]   w_addr;
    logic [NREG-1:0] w_load;

    // While locked the pointer equals the owner, so masking to it restricts eligibility to the owner.
    assign w_elig = (r_state == LOCKED) ? (req_valid & (NREQ'(1) << r_ptr)) : req_valid;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign req_ready = w_gnt;
    assign w_addr    = req_addr[w_idx];
    assign locked    = (r_state == LOCKED);

    // Addresses beyond NREG match no bit, leaving the strobe vector empty.
    always_comb begin
        w_load = '0;
        for (int r = 0; r < NREG; r++) begin
            w_load[r] = w_any && (w_addr == AW'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= IW'(NREQ - 1);
            reg_load <= '0;
            reg_in   <= '0;
            grant_id <= '0;
        end else begin
            reg_load <= w_load;
            if (w_any) begin
                reg_in   <= req_data[w_idx];
                grant_id <= w_idx;
                r_ptr    <= w_idx;
                r_state  <= req_lock[w_idx] ? LOCKED : IDLE;
            end
        end
    end

`ifdef REG_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_gnt[i] && (grant_count[i] != {CNT_W{1'b1}})) begin
                    grant_count[i] <= grant_count[i] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter (NREG=9 so out-of-range addresses are reachable): directed table, reset-mid-burst sequence, random vs reference model.
module tb_reg_write_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_lock;
    logic [3:0][3:0] req_addr;
    logic [3:0][7:0] req_data;
    logic [3:0]      req_ready;
    logic [8:0]      reg_load;
    logic [7:0]      reg_in;
    logic [1:0]      grant_id;
    logic            locked;
`ifdef REG_ARB_STATS_EN
    logic [3:0][15:0] grant_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .NREQ  (4),
        .NREG  (9),
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .reg_load    (reg_load),
        .reg_in      (reg_in),
        .grant_id    (grant_id),
`ifdef REG_ARB_STATS_EN
        .grant_count (grant_count),
`endif
        .locked      (locked)
    );

    typedef struct {
        logic [3:0]      valid;
        logic [3:0]      lock;
        logic [3:0][3:0] addr;
        logic [3:0][7:0] data;
        logic [3:0]      e_rdy;
        logic [8:0]      e_load;
        logic [7:0]      e_in;
        logic [1:0]      e_gid;
        logic            e_lk;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [15:0] a,
                                input logic [31:0] d, input logic [3:0] r, input logic [8:0] ld,
                                input logic [7:0] in, input logic [1:0] g, input logic lk);
        vec_t t;
        t.valid = v;  t.lock = l;  t.addr = a;  t.data = d;
        t.e_rdy = r;  t.e_load = ld;  t.e_in = in;  t.e_gid = g;  t.e_lk = lk;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Entered just after a rising edge: drive, check ready, clock, check registered outputs.
    task automatic apply(input vec_t t, input string tag);
        req_valid = t.valid;
        req_lock  = t.lock;
        req_addr  = t.addr;
        req_data  = t.data;
        #1;
        chk({tag, "_ready"}, {28'h0, req_ready}, {28'h0, t.e_rdy});
        @(posedge clk);
        #1;
        chk({tag, "_load"},   {23'h0, reg_load}, {23'h0, t.e_load});
        chk({tag, "_in"},     {24'h0, reg_in},   {24'h0, t.e_in});
        chk({tag, "_gid"},    {30'h0, grant_id}, {30'h0, t.e_gid});
        chk({tag, "_locked"}, {31'h0, locked},   {31'h0, t.e_lk});
    endtask

    vec_t tv[18];

    // Reference model state
    int          m_ptr;
    int          m_own;
    logic [7:0]  m_in;
    logic [1:0]  m_gid;

    initial begin
        tv[0]  = mk(4'hF, 4'h0, 16'h3210, 32'h13121110, 4'b0001, 9'h001, 8'h10, 2'd0, 1'b0);
        tv[1]  = mk(4'hF, 4'h0, 16'h3210, 32'h13121110, 4'b0010, 9'h002, 8'h11, 2'd1, 1'b0);
        tv[2]  = mk(4'hF, 4'h0, 16'h3210, 32'h13121110, 4'b0100, 9'h004, 8'h12, 2'd2, 1'b0);
        tv[3]  = mk(4'hF, 4'h0, 16'h3210, 32'h13121110, 4'b1000, 9'h008, 8'h13, 2'd3, 1'b0);
        tv[4]  = mk(4'hF, 4'h0, 16'h3210, 32'h13121110, 4'b0001, 9'h001, 8'h10, 2'd0, 1'b0);
        tv[5]  = mk(4'h4, 4'h0, 16'h0500, 32'h00A50000, 4'b0100, 9'h020, 8'hA5, 2'd2, 1'b0);
        tv[6]  = mk(4'h0, 4'h0, 16'h0000, 32'h00000000, 4'b0000, 9'h000, 8'hA5, 2'd2, 1'b0);
        tv[7]  = mk(4'h1, 4'h0, 16'h0001, 32'h00000020, 4'b0001, 9'h002, 8'h20, 2'd0, 1'b0);
        tv[8]  = mk(4'hB, 4'h2, 16'h7031, 32'h73003120, 4'b0010, 9'h008, 8'h31, 2'd1, 1'b1);
        tv[9]  = mk(4'hB, 4'h2, 16'h7031, 32'h73003220, 4'b0010, 9'h008, 8'h32, 2'd1, 1'b1);
        tv[10] = mk(4'hB, 4'h0, 16'h7031, 32'h73003320, 4'b0010, 9'h008, 8'h33, 2'd1, 1'b0);
        tv[11] = mk(4'h9, 4'h0, 16'h7031, 32'h73003320, 4'b1000, 9'h080, 8'h73, 2'd3, 1'b0);
        tv[12] = mk(4'h4, 4'h4, 16'h0000, 32'h00400000, 4'b0100, 9'h001, 8'h40, 2'd2, 1'b1);
        tv[13] = mk(4'hB, 4'h4, 16'h0000, 32'h00000000, 4'b0000, 9'h000, 8'h40, 2'd2, 1'b1);
        tv[14] = mk(4'h1, 4'h0, 16'h0000, 32'h00000000, 4'b0000, 9'h000, 8'h40, 2'd2, 1'b1);
        tv[15] = mk(4'h5, 4'h0, 16'h0000, 32'h00410000, 4'b0100, 9'h001, 8'h41, 2'd2, 1'b0);
        tv[16] = mk(4'h1, 4'h0, 16'h0008, 32'h00000088, 4'b0001, 9'h100, 8'h88, 2'd0, 1'b0);
        tv[17] = mk(4'h1, 4'h0, 16'h000A, 32'h0000008A, 4'b0001, 9'h000, 8'h8A, 2'd0, 1'b0);

        rst = 1'b1;  req_valid = '0;  req_lock = '0;  req_addr = '0;  req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load",   {23'h0, reg_load},  32'h0);
        chk("rst_in",     {24'h0, reg_in},    32'h0);
        chk("rst_gid",    {30'h0, grant_id},  32'h0);
        chk("rst_locked", {31'h0, locked},    32'h0);
        chk("rst_ready",  {28'h0, req_ready}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) apply(tv[i], $sformatf("tv%0d", i));

        // Reset in the cycle after a locked accept, with the owner still presenting a beat.
        apply(mk(4'h2, 4'h2, 16'h0020, 32'h00005500, 4'b0010, 9'h004, 8'h55, 2'd1, 1'b1), "burst");
        rst = 1'b1;
        req_valid = 4'h2;  req_lock = 4'h2;  req_data = 32'h00005600;
        @(posedge clk);
        #1;
        chk("mrst_load",   {23'h0, reg_load}, 32'h0);
        chk("mrst_locked", {31'h0, locked},   32'h0);
        rst = 1'b0;
        apply(mk(4'hF, 4'h0, 16'h3210, 32'h13121110, 4'b0001, 9'h001, 8'h10, 2'd0, 1'b0), "post_rst");

        m_ptr = 0;  m_own = -1;  m_in = 8'h10;  m_gid = 2'd0;
        for (int n = 0; n < 400; n++) begin
            logic [3:0]      v, l, r;
            logic [3:0][3:0] aa;
            logic [3:0][7:0] dd;
            logic [8:0]      ld;
            int              w;
            v  = 4'($urandom);
            l  = 4'($urandom);
            aa = 16'($urandom);
            dd = $urandom;
            w  = -1;
            if (m_own >= 0) begin
                if (v[m_own]) w = m_own;
            end else begin
                for (int k = 1; k <= 4; k++)
                    if (w < 0 && v[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            r  = '0;
            ld = '0;
            if (w >= 0) begin
                r[w] = 1'b1;
                if (aa[w] < 9) ld[aa[w]] = 1'b1;
                m_in  = dd[w];
                m_gid = 2'(w);
                m_ptr = w;
                m_own = l[w] ? w : -1;
            end
            apply(mk(v, l, aa, dd, r, ld, m_in, m_gid, m_own >= 0), "rnd");
        end

`ifdef REG_ARB_STATS_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;  req_valid = 4'h1;  req_lock = 4'h0;
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt0_sat", {16'h0, grant_count[0]}, 32'hFFFF);
        chk("cnt1",     {16'h0, grant_count[1]}, 32'h0);
        chk("cnt2",     {16'h0, grant_count[2]}, 32'h0);
        chk("cnt3",     {16'h0, grant_count[3]}, 32'h0);
        rst = 1'b1;  req_valid = 4'h0;
        @(posedge clk);
        #1;
        chk("cnt_clr",  {32'h0, grant_count} == 96'h0, 32'h1);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
